// File: rtl/wave_pwm_out.sv
// wave_pwm_out: selects and attenuates a generator sample, then emits it as
// a PWM bit whose duty is reloaded only at period boundaries.
module wave_pwm_out #(
    parameter int PERIOD_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] sel,
    input  logic [1:0] amp,
    input  logic [7:0] reciprocal,
    input  logic [7:0] square,
    input  logic [7:0] triangle,
    input  logic [7:0] sine,
    input  logic [7:0] full_wave_rectified,
    input  logic [7:0] half_wave_rectified,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty
);
    localparam logic [PERIOD_BITS-1:0] LAST = '1;

    logic [PERIOD_BITS-1:0] pcnt_q, pcnt_d;
    logic [7:0]             duty_q, sample, next_duty;
    logic                   pwm_q, start_q;

    always_comb begin
        sample = sel == 3'd0 ? reciprocal :
                 sel == 3'd1 ? square :
                 sel == 3'd2 ? triangle :
                 sel == 3'd3 ? sine :
                 sel == 3'd4 ? full_wave_rectified :
                 sel == 3'd5 ? half_wave_rectified : 8'd0;
        next_duty = sample >> amp;
        pcnt_d = pcnt_q + 1'b1;
    end

    // pcnt parks at LAST while disabled so the first enabled edge is a load
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= LAST;
            duty_q  <= 8'd0;
            pwm_q   <= 1'b0;
            start_q <= 1'b0;
        end else if (!en) begin
            pcnt_q  <= LAST;
            pwm_q   <= 1'b0;
            start_q <= 1'b0;
        end else if (pcnt_q == LAST) begin
            pcnt_q  <= '0;
            duty_q  <= next_duty;
            pwm_q   <= next_duty != 8'd0;
            start_q <= 1'b1;
        end else begin
            pcnt_q  <= pcnt_d;
            pwm_q   <= pcnt_d < duty_q;
            start_q <= 1'b0;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = start_q;
    assign duty         = duty_q;
endmodule

// File: doc/wave_pwm_out.md
# wave_pwm_out

Output stage directly downstream of the waveform generator. It selects one of the generator's six 8-bit waveform samples and attenuates it by a programmable right shift. It then converts the result into a single-bit pulse-width-modulated signal for an external RC-filter DAC. The duty value is reloaded only at PWM period boundaries, so source or amplitude changes never produce a truncated or glitched period.

## Interface
Parameters:
- PERIOD_BITS, 8, PWM counter width; period = 2^PERIOD_BITS cycles. Must equal the sample width (8).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  output enable; low parks the PWM engine
- sel  input  3  source select: 0 reciprocal, 1 square, 2 triangle, 3 sine (offset-binary), 4 full_wave_rectified, 5 half_wave_rectified, 6–7 silence
- amp  input  2  attenuation: duty = sample >> amp (0 = full scale, 3 = 1/8)
- reciprocal, square, triangle, sine, full_wave_rectified, half_wave_rectified  input  8 each  unsigned samples from the generator
- pwm_out  output  1  registered PWM bit
- period_start  output  1  one-cycle pulse in the first cycle of each PWM period
- duty  output  8  duty value in force for the current period

## Operation
- Internal registers: pcnt[7:0], duty_q[7:0] (drives duty), pwm_out, period_start.
- next_duty is combinational: the selected sample shifted right by amp. For sel 6/7, next_duty = 0.
- Reset (rst=1, overrides everything): pcnt=255, duty_q=0, pwm_out=0, period_start=0.
- en=0 (rst=0):
  - pcnt forced to 255; pwm_out=0; period_start=0.
  - duty_q holds.
- en=1, pcnt==255 (load cycle):
  - pcnt<=0; duty_q<=next_duty; period_start<=1.
  - pwm_out<=(next_duty!=0).
- en=1, pcnt!=255:
  - pcnt<=pcnt+1; period_start<=0.
  - pwm_out<=((pcnt+1)<duty_q).
- Net effect: pwm_out equals (pcnt_reg < duty_q) for the registered values, so each 256-cycle period has exactly duty_q high cycles, starting at the first cycle of the period.
- Duty extremes:
  - duty 0: pwm_out is constant low.
  - duty 255: 255 cycles high, then 1 cycle low.
  - 100% duty is not reachable by design.
- sel, amp and the sample inputs are sampled only on the load cycle. Changes at any other time are ignored until the next boundary.
- Arithmetic: 8-bit unsigned throughout. The shift fills from the top with zeros. pcnt wraps 255→0 only via the load branch.

## Timing
- First period after rst deasserts (en=1): the load occurs on the first clock edge with rst=0. period_start and pwm_out are valid from the following cycle.
- Re-enabling has the same 1-cycle latency: the first rising edge with en=1 performs the load, because pcnt is parked at 255.
- en deassert mid-period: pwm_out=0 and period_start=0 from the next cycle; no partial-period completion.
- rst mid-period: all outputs take their reset values on the next cycle, regardless of en.
- Steady state: period_start asserts every 256 cycles exactly. duty changes only in the cycle period_start is high.
- Sample-to-PWM latency: a sample present at the load edge affects pwm_out from the very next cycle.

## Test plan
- Reset, then en=1, sel=1, square=0x80, amp=0 → period_start pulses every 256 cycles; pwm_out high exactly 128 cycles per period, starting in the period_start cycle; duty=0x80.
- sel=2, triangle held 0xFF, amp=2 → duty=0x3F; 63 high cycles, 193 low per period. With amp=0 → 255 high, 1 low.
- Mid-period (pcnt=40), change sel from 1 to 3 with sine=0x10 → current period completes with the old duty; the next period has duty=0x10 and 16 high cycles.
- sel=7 with non-zero inputs → pwm_out constant 0; duty=0; period_start still pulses every 256 cycles.
- en dropped at pcnt=100 for 10 cycles, then raised → pwm_out=0 the cycle after the drop; period_start asserted the cycle after the first high-en edge; a full new period follows; duty reloaded from the current inputs.
- rst asserted for 1 cycle at pcnt=200 with en=1 → next cycle pwm_out=0, period_start=0, duty=0; a new period starts 1 cycle after rst deasserts.
